// File: rtl/genevr_regs_pkg.sv
// Shared constants for the generator/replay register ring: ring widths,
// the out-of-range read pattern and the block tags of each pipeline node.
package genevr_regs_pkg;

  localparam int UDP_ADDR_WIDTH = 23;
  localparam int SRC_WIDTH      = 2;
  localparam int DATA_WIDTH     = 32;

  localparam logic [31:0] DEAD_BEEF = 32'hDEAD_BEEF;

  // Block tags occupy the address bits above the 6-bit in-block word offset.
  localparam logic [16:0] GENEVR_GEN_CTRL_BLOCK_ADDR   = 17'h10010;
  localparam logic [16:0] GENEVR_PKT_GEN_BLOCK_ADDR    = 17'h10011;
  localparam logic [16:0] GENEVR_REPLAY_BLOCK_ADDR     = 17'h10012;
  localparam logic [16:0] GENEVR_TIMESTAMP_BLOCK_ADDR  = 17'h10013;
  localparam logic [16:0] GENEVR_RATE_LIMIT_BLOCK_ADDR = 17'h10014;
  localparam logic [16:0] GENEVR_CAPTURE_BLOCK_ADDR    = 17'h10015;
  localparam logic [16:0] GENEVR_OUT_QUEUE_BLOCK_ADDR  = 17'h10016;
  localparam logic [16:0] GENEVR_REG_BANK_BLOCK_ADDR   = 17'h10017;

endpackage

// File: rtl/genevr_sat_counter.sv
// Single event counter that sticks at all-ones; a clear coinciding with an
// increment leaves the count at 1 so that event is not lost.
module genevr_sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = inc ? WIDTH'(1) : '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/genevr_reg_bank.sv
// Register-ring node holding control, status and saturating counter registers
// behind one block tag; every ring output is registered for clean chaining.
module genevr_reg_bank #(
  parameter int DATA_WIDTH     = genevr_regs_pkg::DATA_WIDTH,
  parameter int UDP_ADDR_WIDTH = genevr_regs_pkg::UDP_ADDR_WIDTH,
  parameter int REG_ADDR_WIDTH = 6,
  parameter logic [UDP_ADDR_WIDTH-REG_ADDR_WIDTH-1:0] BLOCK_ADDR =
    genevr_regs_pkg::GENEVR_REG_BANK_BLOCK_ADDR,
  parameter int SRC_WIDTH      = genevr_regs_pkg::SRC_WIDTH,
  parameter int NUM_RW         = 21,
  parameter int NUM_RO         = 8,
  parameter int NUM_CNTR       = 4,
  parameter logic [DATA_WIDTH*NUM_RW-1:0] RW_RESET = '0,
  parameter bit CLEAR_ON_READ  = 1'b1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           reg_req_in,
  input  logic                           reg_ack_in,
  input  logic                           reg_rd_wr_L_in,
  input  logic [UDP_ADDR_WIDTH-1:0]      reg_addr_in,
  input  logic [DATA_WIDTH-1:0]          reg_data_in,
  input  logic [SRC_WIDTH-1:0]           reg_src_in,
  output logic                           reg_req_out,
  output logic                           reg_ack_out,
  output logic                           reg_rd_wr_L_out,
  output logic [UDP_ADDR_WIDTH-1:0]      reg_addr_out,
  output logic [DATA_WIDTH-1:0]          reg_data_out,
  output logic [SRC_WIDTH-1:0]           reg_src_out,
  output logic [DATA_WIDTH*NUM_RW-1:0]   rw_regs,
  output logic [NUM_RW-1:0]              rw_wr_strobe,
  input  logic [DATA_WIDTH*NUM_RO-1:0]   ro_regs,
  input  logic [NUM_CNTR-1:0]            cntr_inc
);

  import genevr_regs_pkg::*;

  localparam int RO_BASE   = NUM_RW;
  localparam int CNTR_BASE = NUM_RW + NUM_RO;
  localparam logic [DATA_WIDTH-1:0] OOR_DATA = DATA_WIDTH'(DEAD_BEEF);

  if (NUM_RW + NUM_RO + NUM_CNTR > 2**REG_ADDR_WIDTH) begin : g_map_overflow
    $error("genevr_reg_bank: register map does not fit in REG_ADDR_WIDTH");
  end

  logic                      claim;
  logic [31:0]               offset;

  logic                      req_q, req_d;
  logic                      ack_q, ack_d;
  logic                      rd_wr_L_q, rd_wr_L_d;
  logic [UDP_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]     data_q, data_d;
  logic [SRC_WIDTH-1:0]      src_q, src_d;
  logic [DATA_WIDTH-1:0]     rw_q [NUM_RW];
  logic [DATA_WIDTH-1:0]     rw_d [NUM_RW];
  logic [NUM_RW-1:0]         strobe_q, strobe_d;
  logic [NUM_CNTR-1:0]       cntr_clr;
  logic [DATA_WIDTH-1:0]     cntr_val [NUM_CNTR];

  assign claim  = reg_req_in && !reg_ack_in &&
                  (reg_addr_in[UDP_ADDR_WIDTH-1:REG_ADDR_WIDTH] == BLOCK_ADDR);
  assign offset = 32'(reg_addr_in[REG_ADDR_WIDTH-1:0]);

  always_comb begin
    req_d     = reg_req_in;
    ack_d     = reg_ack_in;
    rd_wr_L_d = reg_rd_wr_L_in;
    addr_d    = reg_addr_in;
    data_d    = reg_data_in;
    src_d     = reg_src_in;
    rw_d      = rw_q;
    strobe_d  = '0;
    cntr_clr  = '0;

    if (claim) begin
      ack_d = 1'b1;
      if (reg_rd_wr_L_in) begin
        data_d = OOR_DATA;
        for (int i = 0; i < NUM_RW; i++) begin
          if (offset == 32'(i)) data_d = rw_q[i];
        end
        for (int i = 0; i < NUM_RO; i++) begin
          if (offset == 32'(RO_BASE + i)) data_d = ro_regs[DATA_WIDTH*i +: DATA_WIDTH];
        end
        // The old count is returned; a same-cycle increment survives the clear.
        for (int i = 0; i < NUM_CNTR; i++) begin
          if (offset == 32'(CNTR_BASE + i)) begin
            data_d      = cntr_val[i];
            cntr_clr[i] = CLEAR_ON_READ;
          end
        end
      end else begin
        for (int i = 0; i < NUM_RW; i++) begin
          if (offset == 32'(i)) begin
            rw_d[i]     = reg_data_in;
            strobe_d[i] = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_q     <= 1'b0;
      ack_q     <= 1'b0;
      rd_wr_L_q <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      src_q     <= '0;
      strobe_q  <= '0;
      for (int i = 0; i < NUM_RW; i++) begin
        rw_q[i] <= RW_RESET[DATA_WIDTH*i +: DATA_WIDTH];
      end
    end else begin
      req_q     <= req_d;
      ack_q     <= ack_d;
      rd_wr_L_q <= rd_wr_L_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      src_q     <= src_d;
      strobe_q  <= strobe_d;
      rw_q      <= rw_d;
    end
  end

  for (genvar g = 0; g < NUM_CNTR; g++) begin : g_cntr
    genevr_sat_counter #(
      .WIDTH (DATA_WIDTH)
    ) u_cntr (
      .clk   (clk),
      .reset (reset),
      .inc   (cntr_inc[g]),
      .clr   (cntr_clr[g]),
      .count (cntr_val[g])
    );
  end

  for (genvar g = 0; g < NUM_RW; g++) begin : g_rw_out
    assign rw_regs[DATA_WIDTH*g +: DATA_WIDTH] = rw_q[g];
  end

  assign reg_req_out     = req_q;
  assign reg_ack_out     = ack_q;
  assign reg_rd_wr_L_out = rd_wr_L_q;
  assign reg_addr_out    = addr_q;
  assign reg_data_out    = data_q;
  assign reg_src_out     = src_q;
  assign rw_wr_strobe    = strobe_q;

endmodule

// File: tb/tb_genevr_reg_bank.sv
// Directed bench for genevr_reg_bank: a full-size instance plus a narrow
// 8-bit instance without clear-on-read used for counter saturation.
module tb_genevr_reg_bank;

  localparam logic [16:0]  BLK    = 17'h10017;
  localparam logic [671:0] RW_RST = 672'hA5 << 96;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // full-size instance
  logic         req = 0, ack_in = 0, rdwr = 0;
  logic [22:0]  addr = '0;
  logic [31:0]  data_in = '0;
  logic [1:0]   src = '0;
  logic         req_o, ack_o, rdwr_o;
  logic [22:0]  addr_o;
  logic [31:0]  data_o;
  logic [1:0]   src_o;
  logic [671:0] rw_regs;
  logic [20:0]  strobe;
  logic [255:0] ro_regs = '0;
  logic [3:0]   cinc = '0;
  logic [671:0] exp_rw;

  // narrow instance
  logic         req1 = 0, rdwr1 = 0;
  logic [22:0]  addr1 = '0;
  logic [7:0]   data_in1 = '0;
  logic         req_o1, ack_o1, rdwr_o1;
  logic [22:0]  addr_o1;
  logic [7:0]   data_o1;
  logic [1:0]   src_o1;
  logic [7:0]   rw_regs1;
  logic [0:0]   strobe1;
  logic [7:0]   ro1 = 8'h5A;
  logic [0:0]   cinc1 = '0;

  genevr_reg_bank #(
    .NUM_RW (21), .NUM_RO (8), .NUM_CNTR (4),
    .RW_RESET (RW_RST), .CLEAR_ON_READ (1'b1)
  ) u_dut (
    .clk (clk), .reset (reset),
    .reg_req_in (req), .reg_ack_in (ack_in), .reg_rd_wr_L_in (rdwr),
    .reg_addr_in (addr), .reg_data_in (data_in), .reg_src_in (src),
    .reg_req_out (req_o), .reg_ack_out (ack_o), .reg_rd_wr_L_out (rdwr_o),
    .reg_addr_out (addr_o), .reg_data_out (data_o), .reg_src_out (src_o),
    .rw_regs (rw_regs), .rw_wr_strobe (strobe),
    .ro_regs (ro_regs), .cntr_inc (cinc)
  );

  genevr_reg_bank #(
    .DATA_WIDTH (8), .NUM_RW (1), .NUM_RO (1), .NUM_CNTR (1),
    .RW_RESET (8'h00), .CLEAR_ON_READ (1'b0)
  ) u_dut_narrow (
    .clk (clk), .reset (reset),
    .reg_req_in (req1), .reg_ack_in (1'b0), .reg_rd_wr_L_in (rdwr1),
    .reg_addr_in (addr1), .reg_data_in (data_in1), .reg_src_in (2'd1),
    .reg_req_out (req_o1), .reg_ack_out (ack_o1), .reg_rd_wr_L_out (rdwr_o1),
    .reg_addr_out (addr_o1), .reg_data_out (data_o1), .reg_src_out (src_o1),
    .rw_regs (rw_regs1), .rw_wr_strobe (strobe1),
    .ro_regs (ro1), .cntr_inc (cinc1)
  );

  function automatic logic [22:0] mk(input int off);
    logic [5:0] o;
    o = 6'(off);
    return {BLK, o};
  endfunction

  // Drives one request for a cycle; on return (next negedge) outputs reflect it.
  task automatic issue(input logic rd, input logic [22:0] a, input logic [31:0] d,
                       input logic [1:0] s, input logic ai, input logic inc0);
    @(negedge clk);
    req = 1'b1; rdwr = rd; addr = a; data_in = d; src = s; ack_in = ai; cinc[0] = inc0;
    @(negedge clk);
    req = 1'b0; rdwr = 1'b0; addr = '0; data_in = '0; src = '0; ack_in = 1'b0; cinc[0] = 1'b0;
  endtask

  task automatic issue1(input logic rd, input int off, input logic inc);
    @(negedge clk);
    req1 = 1'b1; rdwr1 = rd; addr1 = mk(off); cinc1[0] = inc;
    @(negedge clk);
    req1 = 1'b0; rdwr1 = 1'b0; addr1 = '0; cinc1[0] = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({req_o, ack_o, rdwr_o, addr_o, data_o, src_o} !== '0) begin
      n_fail++; $display("FAIL reset_outs: got %h required 0", {req_o, ack_o, rdwr_o, addr_o, data_o, src_o});
    end
    n_checks++;
    if (rw_regs !== RW_RST) begin
      n_fail++; $display("FAIL reset_rw: got %h required %h", rw_regs, RW_RST);
    end
    n_checks++;
    if (strobe !== '0) begin
      n_fail++; $display("FAIL reset_strobe: got %h required 0", strobe);
    end
    reset = 1'b0;
    exp_rw = RW_RST;
  endtask

  task automatic test_rw;
    issue(1'b1, mk(3), 32'h0, 2'd1, 1'b0, 1'b0);
    n_checks++;
    if ({req_o, ack_o, rdwr_o, src_o, data_o} !== {1'b1, 1'b1, 1'b1, 2'd1, 32'h0000_00A5}) begin
      n_fail++; $display("FAIL rd_reset_val: got ack=%b data=%h required ack=1 data=000000a5", ack_o, data_o);
    end
    n_checks++;
    if (addr_o !== mk(3)) begin
      n_fail++; $display("FAIL rd_addr_echo: got %h required %h", addr_o, mk(3));
    end
    issue(1'b0, mk(0), 32'h1234_5678, 2'd2, 1'b0, 1'b0);
    exp_rw[31:0] = 32'h1234_5678;
    n_checks++;
    if ({ack_o, rdwr_o, data_o} !== {1'b1, 1'b0, 32'h1234_5678}) begin
      n_fail++; $display("FAIL wr_ack: got ack=%b data=%h required ack=1 data=12345678", ack_o, data_o);
    end
    n_checks++;
    if (rw_regs !== exp_rw) begin
      n_fail++; $display("FAIL wr_rw_regs: got %h required %h", rw_regs[31:0], exp_rw[31:0]);
    end
    n_checks++;
    if (strobe !== 21'h1) begin
      n_fail++; $display("FAIL wr_strobe: got %h required 000001", strobe);
    end
    @(negedge clk);
    n_checks++;
    if (strobe !== 21'h0) begin
      n_fail++; $display("FAIL wr_strobe_width: got %h required 0", strobe);
    end
    issue(1'b1, mk(0), 32'h0, 2'd0, 1'b0, 1'b0);
    n_checks++;
    if (data_o !== 32'h1234_5678) begin
      n_fail++; $display("FAIL rd_back: got %h required 12345678", data_o);
    end
  endtask

  task automatic test_ro;
    ro_regs[31:0] = 32'hCAFE_0001;
    ro_regs[255:224] = 32'h7777_0007;
    issue(1'b1, mk(21), 32'h0, 2'd0, 1'b0, 1'b0);
    n_checks++;
    if ({ack_o, data_o} !== {1'b1, 32'hCAFE_0001}) begin
      n_fail++; $display("FAIL ro_read: got ack=%b data=%h required ack=1 data=cafe0001", ack_o, data_o);
    end
    issue(1'b1, mk(28), 32'h0, 2'd0, 1'b0, 1'b0);
    n_checks++;
    if (data_o !== 32'h7777_0007) begin
      n_fail++; $display("FAIL ro_read_last: got %h required 77770007", data_o);
    end
    issue(1'b0, mk(21), 32'h5555_AAAA, 2'd3, 1'b0, 1'b0);
    n_checks++;
    if ({ack_o, data_o, strobe} !== {1'b1, 32'h5555_AAAA, 21'h0}) begin
      n_fail++; $display("FAIL ro_write: got ack=%b data=%h strobe=%h required 1 5555aaaa 0", ack_o, data_o, strobe);
    end
    n_checks++;
    if (rw_regs !== exp_rw) begin
      n_fail++; $display("FAIL ro_write_rw: got %h required %h", rw_regs, exp_rw);
    end
  endtask

  task automatic test_counter;
    @(negedge clk); cinc[0] = 1'b1;
    repeat (5) @(negedge clk);
    cinc[0] = 1'b0;
    issue(1'b1, mk(29), 32'h0, 2'd0, 1'b0, 1'b1);
    n_checks++;
    if ({ack_o, data_o} !== {1'b1, 32'd5}) begin
      n_fail++; $display("FAIL cntr_rd_inc: got ack=%b data=%h required ack=1 data=5", ack_o, data_o);
    end
    issue(1'b1, mk(29), 32'h0, 2'd0, 1'b0, 1'b0);
    n_checks++;
    if (data_o !== 32'd1) begin
      n_fail++; $display("FAIL cntr_after_clr: got %h required 1", data_o);
    end
    issue(1'b1, mk(29), 32'h0, 2'd0, 1'b0, 1'b0);
    n_checks++;
    if (data_o !== 32'd0) begin
      n_fail++; $display("FAIL cntr_cleared: got %h required 0", data_o);
    end
    issue(1'b1, mk(32), 32'h0, 2'd0, 1'b0, 1'b0);
    n_checks++;
    if ({ack_o, data_o} !== {1'b1, 32'd0}) begin
      n_fail++; $display("FAIL cntr_last: got ack=%b data=%h required ack=1 data=0", ack_o, data_o);
    end
  endtask

  task automatic test_out_of_range;
    issue(1'b1, mk(40), 32'h0, 2'd0, 1'b0, 1'b0);
    n_checks++;
    if ({ack_o, data_o} !== {1'b1, 32'hDEAD_BEEF}) begin
      n_fail++; $display("FAIL oor_40: got ack=%b data=%h required ack=1 data=deadbeef", ack_o, data_o);
    end
    issue(1'b1, mk(33), 32'h0, 2'd0, 1'b0, 1'b0);
    n_checks++;
    if (data_o !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL oor_33: got %h required deadbeef", data_o);
    end
    issue(1'b0, mk(40), 32'h0000_F00D, 2'd0, 1'b0, 1'b0);
    n_checks++;
    if ({ack_o, data_o, strobe} !== {1'b1, 32'h0000_F00D, 21'h0} || rw_regs !== exp_rw) begin
      n_fail++; $display("FAIL oor_write: got ack=%b data=%h strobe=%h required 1 0000f00d 0", ack_o, data_o, strobe);
    end
  endtask

  task automatic test_pass_through;
    issue(1'b0, {17'h10016, 6'd0}, 32'hAAAA_5555, 2'd2, 1'b0, 1'b0);
    n_checks++;
    if ({req_o, ack_o, rdwr_o, addr_o, data_o, src_o} !==
        {1'b1, 1'b0, 1'b0, {17'h10016, 6'd0}, 32'hAAAA_5555, 2'd2}) begin
      n_fail++; $display("FAIL pt_foreign: got ack=%b addr=%h data=%h src=%0d required 0 %h aaaa5555 2",
                         ack_o, addr_o, data_o, src_o, {17'h10016, 6'd0});
    end
    n_checks++;
    if (rw_regs !== exp_rw || strobe !== '0) begin
      n_fail++; $display("FAIL pt_foreign_rw: got strobe=%h rw0=%h required 0 %h", strobe, rw_regs[31:0], exp_rw[31:0]);
    end
    issue(1'b1, mk(3), 32'h0BAD_F00D, 2'd1, 1'b1, 1'b0);
    n_checks++;
    if ({req_o, ack_o, rdwr_o, data_o, src_o} !== {1'b1, 1'b1, 1'b1, 32'h0BAD_F00D, 2'd1}) begin
      n_fail++; $display("FAIL pt_acked_rd: got ack=%b data=%h required ack=1 data=0badf00d", ack_o, data_o);
    end
    issue(1'b0, mk(0), 32'hFFFF_0000, 2'd0, 1'b1, 1'b0);
    n_checks++;
    if (rw_regs !== exp_rw || strobe !== '0 || data_o !== 32'hFFFF_0000) begin
      n_fail++; $display("FAIL pt_acked_wr: got rw0=%h strobe=%h data=%h required %h 0 ffff0000",
                         rw_regs[31:0], strobe, data_o, exp_rw[31:0]);
    end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    req = 1'b1; rdwr = 1'b0; addr = mk(1); data_in = 32'h0000_0011;
    @(negedge clk);
    exp_rw[63:32] = 32'h0000_0011;
    n_checks++;
    if ({ack_o, data_o, strobe} !== {1'b1, 32'h0000_0011, 21'h2}) begin
      n_fail++; $display("FAIL b2b_wr: got ack=%b data=%h strobe=%h required 1 00000011 000002", ack_o, data_o, strobe);
    end
    rdwr = 1'b1; addr = mk(1); data_in = '0;
    @(negedge clk);
    req = 1'b0; rdwr = 1'b0; addr = '0;
    n_checks++;
    if ({ack_o, rdwr_o, data_o, strobe} !== {1'b1, 1'b1, 32'h0000_0011, 21'h0}) begin
      n_fail++; $display("FAIL b2b_rd: got ack=%b data=%h strobe=%h required 1 00000011 0", ack_o, data_o, strobe);
    end
    @(negedge clk);
    n_checks++;
    if ({req_o, ack_o} !== 2'b00 || rw_regs !== exp_rw) begin
      n_fail++; $display("FAIL b2b_idle: got req=%b ack=%b required 0 0", req_o, ack_o);
    end
  endtask

  task automatic test_saturation;
    @(negedge clk); cinc1[0] = 1'b1;
    repeat (3) @(negedge clk);
    cinc1[0] = 1'b0;
    issue1(1'b1, 2, 1'b1);
    n_checks++;
    if ({ack_o1, data_o1} !== {1'b1, 8'd3}) begin
      n_fail++; $display("FAIL nocor_rd_inc: got ack=%b data=%h required ack=1 data=03", ack_o1, data_o1);
    end
    issue1(1'b1, 2, 1'b0);
    n_checks++;
    if (data_o1 !== 8'd4) begin
      n_fail++; $display("FAIL nocor_after: got %h required 04", data_o1);
    end
    @(negedge clk); cinc1[0] = 1'b1;
    repeat (300) @(negedge clk);
    cinc1[0] = 1'b0;
    issue1(1'b1, 2, 1'b1);
    n_checks++;
    if (data_o1 !== 8'hFF) begin
      n_fail++; $display("FAIL sat_read: got %h required ff", data_o1);
    end
    issue1(1'b1, 2, 1'b0);
    n_checks++;
    if (data_o1 !== 8'hFF) begin
      n_fail++; $display("FAIL sat_hold: got %h required ff", data_o1);
    end
    issue1(1'b1, 1, 1'b0);
    n_checks++;
    if (data_o1 !== 8'h5A) begin
      n_fail++; $display("FAIL narrow_ro: got %h required 5a", data_o1);
    end
    issue1(1'b1, 7, 1'b0);
    n_checks++;
    if ({ack_o1, data_o1} !== {1'b1, 8'hEF}) begin
      n_fail++; $display("FAIL narrow_oor: got ack=%b data=%h required ack=1 data=ef", ack_o1, data_o1);
    end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    req = 1'b1; rdwr = 1'b0; addr = mk(3); data_in = 32'h0000_0055;
    #3 reset = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({req_o, ack_o, strobe} !== {1'b0, 1'b0, 21'h0}) begin
      n_fail++; $display("FAIL rst_mid_ack: got req=%b ack=%b strobe=%h required 0 0 0", req_o, ack_o, strobe);
    end
    n_checks++;
    if (rw_regs !== RW_RST) begin
      n_fail++; $display("FAIL rst_mid_rw: got %h required %h", rw_regs, RW_RST);
    end
    @(negedge clk);
    req = 1'b0; addr = '0; data_in = '0;
    reset = 1'b0;
    issue(1'b1, mk(3), 32'h0, 2'd0, 1'b0, 1'b0);
    n_checks++;
    if ({ack_o, data_o} !== {1'b1, 32'h0000_00A5}) begin
      n_fail++; $display("FAIL rst_mid_readback: got ack=%b data=%h required ack=1 data=000000a5", ack_o, data_o);
    end
  endtask

  initial begin
    test_reset;
    test_rw;
    test_ro;
    test_counter;
    test_out_of_range;
    test_pass_through;
    test_back_to_back;
    test_saturation;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
